sparc_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage SPARC pipeline. It watches the register-destination and control fields that flow forward out of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and drives the backward path. That path consists of the load enables and squash requests for those registers, plus forwarding mux selects for the ID-stage operand readers. It also holds a small freeze FSM for data-memory wait states, a pending-branch latch, and saturating stall/flush statistics counters.

---
 rtl/sparc_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_sparc_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sparc_hazard_ctrl.sv
// Hazard/stall controller for the five-stage SPARC pipeline: operand forwarding,
// load-use bubbles, branch squash, data-memory freeze and stall/flush statistics.
module sparc_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_rd_used,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_rf_we,
  input  logic             mem_rf_we,
  input  logic             wb_rf_we,
  input  logic             ex_load,
  input  logic             br_taken,
  input  logic             br_annul,
  input  logic             mem_busy,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             id_ex_le,
  output logic             ex_mem_le,
  output logic             mem_wb_le,
  output logic             if_id_reset,
  output logic             id_ex_reset,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             state
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             br_pend_reg, br_pend_next;
  logic             pend_annul_reg, pend_annul_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             stall_inc, flush_inc;
  logic             load_use;

  // A loaded value is not available until MEM, so an EX load never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && src != 5'd0) begin
      if (ex_rf_we && !ex_load && ex_rd == src)
        sel = 2'b01;
      else if (mem_rf_we && mem_rd == src)
        sel = 2'b10;
      else if (wb_rf_we && wb_rd == src)
        sel = 2'b11;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(id_rs1, id_rs1_used);
  assign fwd_b = fwd_sel(id_rs2, id_rs2_used);
  assign fwd_d = fwd_sel(id_rd, id_rd_used);

  assign load_use = ex_load && ex_rf_we && ex_rd != 5'd0 &&
                    ((id_rs1_used && id_rs1 == ex_rd) ||
                     (id_rs2_used && id_rs2 == ex_rd) ||
                     (id_rd_used  && id_rd  == ex_rd));

  // RUN and MEM_WAIT share the same rule chain; only the freeze keeps us in MEM_WAIT.
  always_comb begin
    pc_le           = 1'b1;
    if_id_le        = 1'b1;
    id_ex_le        = 1'b1;
    ex_mem_le       = 1'b1;
    mem_wb_le       = 1'b1;
    if_id_reset     = 1'b0;
    id_ex_reset     = 1'b0;
    state_next      = RUN;
    br_pend_next    = br_pend_reg;
    pend_annul_next = pend_annul_reg;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (mem_busy) begin
      pc_le      = 1'b0;
      if_id_le   = 1'b0;
      id_ex_le   = 1'b0;
      ex_mem_le  = 1'b0;
      mem_wb_le  = 1'b0;
      state_next = MEM_WAIT;
      stall_inc  = 1'b1;
      if (br_taken) begin
        br_pend_next    = 1'b1;
        pend_annul_next = br_annul;
      end
    end else if (load_use) begin
      pc_le       = 1'b0;
      if_id_le    = 1'b0;
      id_ex_reset = 1'b1;
      stall_inc   = 1'b1;
    end else if (br_taken || br_pend_reg) begin
      if_id_reset  = 1'b1;
      id_ex_reset  = br_taken ? br_annul : pend_annul_reg;
      flush_inc    = 1'b1;
      br_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg      <= RUN;
      br_pend_reg    <= 1'b0;
      pend_annul_reg <= 1'b0;
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      br_pend_reg    <= br_pend_next;
      pend_annul_reg <= pend_annul_next;
      if (stall_inc && stall_cnt_reg != {CNT_W{1'b1}})
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && flush_cnt_reg != {CNT_W{1'b1}})
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
  assign state     = (state_reg == MEM_WAIT);

endmodule

// File: tb/tb_sparc_hazard_ctrl.sv
// Directed self-checking bench for sparc_hazard_ctrl (4-bit counters so saturation is reachable).
module tb_sparc_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic clr;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
  logic id_rs1_used, id_rs2_used, id_rd_used;
  logic ex_rf_we, mem_rf_we, wb_rf_we, ex_load, br_taken, br_annul, mem_busy;
  logic pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le, if_id_reset, id_ex_reset;
  logic [1:0] fwd_a, fwd_b, fwd_d;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic state;
  logic [4:0] les;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign les = {pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le};

  sparc_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_used(id_rd_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
    .ex_load(ex_load), .br_taken(br_taken), .br_annul(br_annul), .mem_busy(mem_busy),
    .pc_le(pc_le), .if_id_le(if_id_le), .id_ex_le(id_ex_le), .ex_mem_le(ex_mem_le),
    .mem_wb_le(mem_wb_le), .if_id_reset(if_id_reset), .id_ex_reset(id_ex_reset),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd_used = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_rf_we = 0; mem_rf_we = 0; wb_rf_we = 0;
    ex_load = 0; br_taken = 0; br_annul = 0; mem_busy = 0;
  endtask

  // Move to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {id_rs1, id_rs2, id_rd, ex_rd, mem_rd} = 25'($urandom);
      {wb_rd, id_rs1_used, id_rs2_used, id_rd_used, ex_rf_we, mem_rf_we, wb_rf_we,
       ex_load, br_taken, br_annul, mem_busy} = 15'($urandom);
      tick();
      n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b want 0", state); end
      n_cmp++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_err++;
        $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt); end
    end
    idle();
    @(negedge clk);
    clr = 1'b1;
    tick();
    n_cmp++; if (les !== 5'b11111) begin n_err++; $display("FAIL reset_les: got %b want 11111", les); end
    n_cmp++; if ({if_id_reset, id_ex_reset} !== 2'b00) begin n_err++;
      $display("FAIL reset_resets: got %b want 00", {if_id_reset, id_ex_reset}); end
    n_cmp++; if ({fwd_a, fwd_b, fwd_d} !== 6'd0) begin n_err++;
      $display("FAIL reset_fwd: got %b want 000000", {fwd_a, fwd_b, fwd_d}); end
    n_cmp++; if (state !== 1'b0 || stall_cnt !== 4'd0) begin n_err++;
      $display("FAIL reset_after: got state=%b stall=%0d want 0/0", state, stall_cnt); end
  endtask

  task automatic test_forwarding();
    tick();
    id_rs1 = 5; id_rs1_used = 1; ex_rd = 5; ex_rf_we = 1; mem_rd = 5; mem_rf_we = 1;
    #1;
    n_cmp++; if (fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_ex: got %b want 01", fwd_a); end
    ex_rf_we = 0; #1;
    n_cmp++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_mem: got %b want 10", fwd_a); end
    mem_rf_we = 0; wb_rd = 5; wb_rf_we = 1; #1;
    n_cmp++; if (fwd_a !== 2'b11) begin n_err++; $display("FAIL fwd_wb: got %b want 11", fwd_a); end
    id_rs1 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_rf_we = 1; mem_rf_we = 1; #1;
    n_cmp++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_g0: got %b want 00", fwd_a); end
    id_rs1 = 5; ex_rd = 5; id_rs1_used = 0; #1;
    n_cmp++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_unused: got %b want 00", fwd_a); end
    idle();
    id_rs2 = 9; id_rs2_used = 1; mem_rd = 9; mem_rf_we = 1;
    id_rd = 3; id_rd_used = 1; wb_rd = 3; wb_rf_we = 1; #1;
    n_cmp++; if ({fwd_a, fwd_b, fwd_d} !== 6'b00_10_11) begin n_err++;
      $display("FAIL fwd_bd: got %b want 001011", {fwd_a, fwd_b, fwd_d}); end
    // EX load must not forward; MEM copy of the same register wins instead.
    idle();
    id_rs1 = 5; id_rs1_used = 1; ex_rd = 5; ex_rf_we = 1; ex_load = 1; mem_rd = 5; mem_rf_we = 1; #1;
    n_cmp++; if (fwd_a !== 2'b10 || pc_le !== 1'b0) begin n_err++;
      $display("FAIL fwd_load: got fwd_a=%b pc_le=%b want 10/0", fwd_a, pc_le); end
    idle();
  endtask

  task automatic test_load_use();
    tick();
    ex_load = 1; ex_rd = 7; ex_rf_we = 1; id_rs2 = 7; id_rs2_used = 1; #1;
    n_cmp++; if (les !== 5'b00111 || {if_id_reset, id_ex_reset} !== 2'b01) begin n_err++;
      $display("FAIL load_use: got les=%b rst=%b want 00111/01", les, {if_id_reset, id_ex_reset}); end
    tick();
    idle();
    #1;
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
    n_cmp++; if (les !== 5'b11111 || id_ex_reset !== 1'b0) begin n_err++;
      $display("FAIL load_use_end: got les=%b id_ex_reset=%b want 11111/0", les, id_ex_reset); end
  endtask

  task automatic test_branch();
    tick();
    br_taken = 1; br_annul = 0; #1;
    n_cmp++; if (les !== 5'b11111 || {if_id_reset, id_ex_reset} !== 2'b10) begin n_err++;
      $display("FAIL br_noannul: got les=%b rst=%b want 11111/10", les, {if_id_reset, id_ex_reset}); end
    tick();
    br_annul = 1; #1;
    n_cmp++; if (flush_cnt !== 4'd1) begin n_err++; $display("FAIL br_cnt1: got %0d want 1", flush_cnt); end
    n_cmp++; if ({if_id_reset, id_ex_reset} !== 2'b11) begin n_err++;
      $display("FAIL br_annul: got %b want 11", {if_id_reset, id_ex_reset}); end
    tick();
    idle(); #1;
    n_cmp++; if (flush_cnt !== 4'd2 || if_id_reset !== 1'b0) begin n_err++;
      $display("FAIL br_cnt2: got flush=%0d if_id_reset=%b want 2/0", flush_cnt, if_id_reset); end
  endtask

  task automatic test_freeze_branch();
    tick();
    mem_busy = 1; br_taken = 1; br_annul = 1; #1;
    n_cmp++; if (les !== 5'b00000 || {if_id_reset, id_ex_reset} !== 2'b00) begin n_err++;
      $display("FAIL frz_first: got les=%b rst=%b want 00000/00", les, {if_id_reset, id_ex_reset}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      br_taken = 0; br_annul = 0; #1;
      n_cmp++; if (les !== 5'b00000 || state !== 1'b1 || if_id_reset !== 1'b0) begin n_err++;
        $display("FAIL frz_hold%0d: got les=%b state=%b if_id_reset=%b want 00000/1/0",
                 i, les, state, if_id_reset); end
    end
    tick();
    mem_busy = 0; #1;
    n_cmp++; if (les !== 5'b11111 || {if_id_reset, id_ex_reset} !== 2'b11 || state !== 1'b1) begin n_err++;
      $display("FAIL frz_release: got les=%b rst=%b state=%b want 11111/11/1",
               les, {if_id_reset, id_ex_reset}, state); end
    tick();
    n_cmp++; if (state !== 1'b0 || stall_cnt !== 4'd4 || flush_cnt !== 4'd3) begin n_err++;
      $display("FAIL frz_after: got state=%b stall=%0d flush=%0d want 0/4/3", state, stall_cnt, flush_cnt); end
    n_cmp++; if (if_id_reset !== 1'b0) begin n_err++;
      $display("FAIL frz_once: got if_id_reset=%b want 0", if_id_reset); end
  endtask

  task automatic test_clr_mid_freeze();
    tick();
    mem_busy = 1; br_taken = 1; br_annul = 1;
    ex_load = 1; ex_rd = 4; ex_rf_we = 1; id_rs1 = 4; id_rs1_used = 1; #1;
    n_cmp++; if (les !== 5'b00000 || id_ex_reset !== 1'b0) begin n_err++;
      $display("FAIL busy_prio: got les=%b id_ex_reset=%b want 00000/0", les, id_ex_reset); end
    tick();
    idle(); mem_busy = 1; #1;
    clr = 1'b0; #1;
    n_cmp++; if (state !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_err++;
      $display("FAIL clr_async: got state=%b stall=%0d flush=%0d want 0/0/0", state, stall_cnt, flush_cnt); end
    mem_busy = 0;
    @(negedge clk);
    clr = 1'b1;
    #1;
    n_cmp++; if (if_id_reset !== 1'b0 || les !== 5'b11111) begin n_err++;
      $display("FAIL clr_pend: got if_id_reset=%b les=%b want 0/11111", if_id_reset, les); end
  endtask

  task automatic test_saturation();
    tick();
    ex_load = 1; ex_rd = 12; ex_rf_we = 1; id_rd = 12; id_rd_used = 1;
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_reach: got %0d want 15", stall_cnt); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (stall_cnt !== 4'd15 || flush_cnt !== 4'd0) begin n_err++;
      $display("FAIL sat_hold: got stall=%0d flush=%0d want 15/0", stall_cnt, flush_cnt); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_freeze_branch();
    test_clr_mid_freeze();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
